// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider, glitch-free ratio updates.
// Optional CLK_DIV_MULTI_SYNC_EN adds a sync input for phase alignment.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 60,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin1,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err,
  output logic              locked
);
  localparam int HW = DIV_W + 1;
  localparam logic [15:0] LK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [15:0]       lock_cnt;
  logic [DIV_W-1:0]  div_q  [NUM_CH];
  logic [DIV_W-1:0]  pdiv_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [HW-1:0]     half   [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] xfer_ch;
  logic              xfer;
  logic              sync_go;
  logic [DIV_W-1:0]  wr_div;

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign sync_go = locked & sync;
`else
  assign sync_go = 1'b0;
`endif

  // channel select is one-hot; out-of-range channels are never ready
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      sel[i] = (cfg_ch == CH_W'(i));
  end

  assign cfg_ready = locked & (|sel) & ~(|(sel & pend_q));
  assign xfer      = cfg_valid & cfg_ready;
  assign xfer_ch   = sel & {NUM_CH{xfer}};
  assign wr_div    = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

  always_comb begin
    run   = '0;
    wrap  = '0;
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      half[i]  = ({1'b0, div_q[i]} + HW'(1)) >> 1;
      run[i]   = locked & ch_en[i];
      wrap[i]  = run[i] & (cnt_q[i] == div_q[i] - ONE);
      apply[i] = pend_q[i] & (~run[i] | wrap[i] | sync_go);
    end
  end

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
      cfg_err  <= 1'b0;
      pend_q   <= '0;
      clk_out  <= '0;
      tick     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= DIV_RST;
        pdiv_q[i] <= DIV_RST;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (!locked) begin
        if (lock_cnt == LK_LAST)
          locked <= 1'b1;
        else
          lock_cnt <= lock_cnt + 16'd1;
      end
      if (xfer && (cfg_div < DIV_MIN))
        cfg_err <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (run[i]) begin
          tick[i]    <= (cnt_q[i] == '0);
          clk_out[i] <= ({1'b0, cnt_q[i]} < half[i]);
          cnt_q[i]   <= (wrap[i] | sync_go) ? '0 : cnt_q[i] + ONE;
        end else begin
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
          cnt_q[i]   <= '0;
        end
        // new ratio takes effect only at a period boundary
        if (apply[i])
          div_q[i] <= pdiv_q[i];
        if (xfer_ch[i])
          pdiv_q[i] <= wr_div;
        pend_q[i] <= xfer_ch[i] | (pend_q[i] & ~apply[i]);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: period-start-time reference model,
// directed phases followed by randomized writes and enables.
module tb_clk_div_multi;
  localparam int NCH   = 4;
  localparam int LOCKC = 16;
  localparam int DDEF  = 60;

  logic       clkin1 = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] ch_en;
  logic       sync_i;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic       cfg_err;
  logic       locked;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  int   edges;
  bit   lk_m;
  bit   err_m;
  int   dcur [NCH];
  int   pdiv [NCH];
  int   ps   [NCH];
  int   nb   [NCH];
  bit   pend_m  [NCH];
  bit   was_run [NCH];
  logic [3:0] e_clk;
  logic [3:0] e_tick;

  clk_div_multi #(
    .NUM_CH(NCH),
    .DIV_W(8),
    .DEFAULT_DIV(DDEF),
    .LOCK_CYCLES(LOCKC)
  ) dut (
    .clkin1(clkin1),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .ch_en(ch_en),
`ifdef CLK_DIV_MULTI_SYNC_EN
    .sync(sync_i),
`endif
    .clk_out(clk_out),
    .tick(tick),
    .cfg_err(cfg_err),
    .locked(locked)
  );

  always #5 clkin1 = ~clkin1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    edges = 0;
    lk_m  = 1'b0;
    err_m = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      dcur[i]    = DDEF;
      pdiv[i]    = DDEF;
      ps[i]      = 0;
      nb[i]      = 0;
      pend_m[i]  = 1'b0;
      was_run[i] = 1'b0;
    end
    e_clk  = '0;
    e_tick = '0;
  endfunction

  // Each period begins at edge ps and the next one at edge nb; a
  // pending ratio lands on the edge before nb (or at once if idle/sync).
  function automatic void model_edge();
    bit xfer;
    bit run;
    bit sy;
    int e;
    int ph;
    int c;
    c = int'(cfg_ch);
    xfer = cfg_valid && lk_m && !pend_m[c];
    sy = sync_i && lk_m;
    edges++;
    e = edges;
    for (int i = 0; i < NCH; i++) begin
      run = lk_m && ch_en[i];
      if (!run) begin
        e_clk[i]   = 1'b0;
        e_tick[i]  = 1'b0;
        was_run[i] = 1'b0;
        if (pend_m[i]) begin
          dcur[i]   = pdiv[i];
          pend_m[i] = 1'b0;
        end
      end else begin
        if (!was_run[i] || e == nb[i]) begin
          ps[i] = e;
          nb[i] = e + dcur[i];
        end
        ph = e - ps[i];
        e_tick[i] = (ph == 0);
        e_clk[i]  = (ph < (dcur[i] + 1) / 2);
        if (pend_m[i] && (sy || e == nb[i] - 1)) begin
          dcur[i]   = pdiv[i];
          pend_m[i] = 1'b0;
        end
        if (sy)
          nb[i] = e + 1;
        was_run[i] = 1'b1;
      end
    end
    if (xfer) begin
      pend_m[c] = 1'b1;
      pdiv[c] = (cfg_div < 2) ? 2 : int'(cfg_div);
      if (cfg_div < 2)
        err_m = 1'b1;
    end
    if (!lk_m && e == LOCKC)
      lk_m = 1'b1;
  endfunction

  task automatic cyc(input bit v, input int ch,
                     input int dv, input bit sy);
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(dv);
    sync_i    = sy;
    #1;
    chk("cfg_ready", 32'(cfg_ready),
        32'(lk_m && !pend_m[ch]));
    @(posedge clkin1);
    model_edge();
    #1;
    chk("clk_out", 32'(clk_out), 32'(e_clk));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("locked", 32'(locked), 32'(lk_m));
    chk("cfg_err", 32'(cfg_err), 32'(err_m));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    @(negedge clkin1);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int v;
    int ch;
    int dv;
    int j;
    bit sy;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    ch_en     = '0;
    sync_i    = 1'b0;
    model_reset();
    repeat (3) @(posedge clkin1);
    #1;
    chk("init_clk", 32'(clk_out), 32'h0);
    chk("init_tick", 32'(tick), 32'h0);
    chk("init_locked", 32'(locked), 32'h0);
    chk("init_err", 32'(cfg_err), 32'h0);
    ch_en = 4'hF;
    @(negedge clkin1);
    rst = 1'b0;

    idle(LOCKC - 1);
    chk("prelock", 32'(locked), 32'h0);
    chk("prelock_clk", 32'(clk_out), 32'h0);
    idle(1);
    chk("lock_edge", 32'(locked), 32'h1);
    idle(1);
    chk("first_tick", 32'(tick), 32'hF);

    idle(125);

    idle(17);
    cyc(1'b1, 1, 5, 1'b0);
    idle(80);
    for (int k = 0; k < NCH; k++)
      cyc(1'b0, k, 0, 1'b0);

    cyc(1'b1, 2, 7, 1'b0);
    repeat (4) cyc(1'b1, 2, 3, 1'b0);
    cyc(1'b1, 0, 9, 1'b0);
    idle(130);
    cyc(1'b1, 2, 3, 1'b0);
    idle(20);

    cyc(1'b1, 3, 1, 1'b0);
    idle(80);
    chk("err_sticky", 32'(cfg_err), 32'h1);

    for (int n = 0; n < 1500; n++) begin
      v  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ch = $urandom_range(0, 3);
      dv = $urandom_range(0, 9);
      if ($urandom_range(0, 15) == 0)
        dv = $urandom_range(10, 255);
      sy = 1'b0;
`ifdef CLK_DIV_MULTI_SYNC_EN
      sy = ($urandom_range(0, 59) == 0);
`endif
      if ($urandom_range(0, 49) == 0) begin
        j = $urandom_range(0, 3);
        ch_en[j] = ~ch_en[j];
      end
      cyc(v[0], ch, dv, sy);
    end

    ch_en = 4'hF;
    idle(37);
    do_reset();
    idle(LOCKC + 1);
    chk("relock_tick", 32'(tick), 32'hF);

`ifdef CLK_DIV_MULTI_SYNC_EN
    cyc(1'b1, 0, 4, 1'b0);
    cyc(1'b1, 1, 6, 1'b0);
    idle(70 + $urandom_range(0, 11));
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0);
    chk("sync_align", 32'(tick), 32'hF);
    idle(13);
    do_reset();
    idle(5);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
